muldiv_alu: RTL and testbench

MULDIV_ALU -- requirements
Module: muldiv_alu

---
 rtl/muldiv_alu.sv | 97 +++++++++
 tb/tb_muldiv_alu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_alu.sv
// muldiv_alu: single-cycle logic/arith ALU plus iterative shift-add multiply and restoring divide
module muldiv_alu #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic         zero,
  output logic         div_by_zero
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  localparam int CW = $clog2(N);
  logic [1:0] state;
  logic is_div, accept, multi, qb;
  logic [CW-1:0] cnt;
  logic [N-1:0] opb, acc_hi, acc_lo, nhi, nlo, alu_r;
  logic [N:0] madd, dsh, dsub;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  assign multi = op == 4'b1000 || (op == 4'b1001 && b != '0);
  // acc_hi/acc_lo is the product (multiplier shifts out of acc_lo) or remainder/quotient pair
  assign madd = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign dsh = {acc_hi, acc_lo[N-1]};
  assign dsub = dsh - {1'b0, opb};
  assign qb = ~dsub[N];
  assign nhi = is_div ? (qb ? dsub[N-1:0] : dsh[N-1:0]) : madd[N:1];
  assign nlo = is_div ? {acc_lo[N-2:0], qb} : {madd[0], acc_lo[N-1:1]};
  always_comb begin
    case (op)
      4'b0000: alu_r = a & b;
      4'b0001: alu_r = a | b;
      4'b0010: alu_r = a + b;
      4'b0011: alu_r = {{(N-1){1'b0}}, a < b};
      4'b0100: alu_r = a & ~b;
      4'b0101: alu_r = a | ~b;
      4'b0110: alu_r = a - b;
      4'b0111: alu_r = {{(N-1){1'b0}}, $signed(a) < $signed(b)};
      4'b1001: alu_r = '1;
      default: alu_r = '0;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      is_div <= 1'b0;
      cnt <= '0;
      opb <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      result <= '0;
      result_hi <= '0;
      zero <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          opb <= b;
          acc_hi <= '0;
          acc_lo <= a;
          cnt <= '0;
          is_div <= op[0];
          if (multi) state <= BUSY;
          else begin
            state <= DONE;
            result <= alu_r;
            result_hi <= op == 4'b1001 ? a : '0;
            zero <= alu_r == '0;
            div_by_zero <= op == 4'b1001;
          end
        end
        BUSY: begin
          acc_hi <= nhi;
          acc_lo <= nlo;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state <= DONE;
            result <= nlo;
            result_hi <= nhi;
            zero <= nlo == '0;
            div_by_zero <= 1'b0;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_alu.sv
// tb_muldiv_alu: randomized scoreboard bench; driver pushes model results, negedge monitor pops and compares
module tb_muldiv_alu;
  typedef struct {
    logic [31:0] r;
    logic [31:0] h;
    logic z;
    logic d;
    int lat;
  } exp_t;
  logic clk = 1'b0, resetn, in_valid, in_ready, out_valid, out_ready, zero, div_by_zero;
  logic [3:0] op;
  logic [31:0] a, b, result, result_hi;
  int cyc = 0, n_cmp = 0, n_bad = 0, acc_cyc = 0, lat = 0, bp_mode = 2;
  bit seen = 0, inflight = 0, idle_chk = 0;
  logic [65:0] snap;
  exp_t exp_q[$];

  muldiv_alu #(.N(32)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .result_hi(result_hi),
    .zero(zero), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1 out_ready = bp_mode == 0 ? $urandom_range(0, 3) != 0 : bp_mode == 2;
  end

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [63:0] p;
    e.h = 0;
    e.d = 0;
    e.lat = 1;
    case (o)
      4'd0: e.r = x & y;
      4'd1: e.r = x | y;
      4'd2: e.r = x + y;
      4'd3: e.r = x < y ? 32'd1 : 32'd0;
      4'd4: e.r = x & ~y;
      4'd5: e.r = x | ~y;
      4'd6: e.r = x - y;
      4'd7: e.r = $signed(x) < $signed(y) ? 32'd1 : 32'd0;
      4'd8: begin
        p = 64'(x) * 64'(y);
        e.r = p[31:0];
        e.h = p[63:32];
        e.lat = 33;
      end
      4'd9: if (y == 0) begin
        e.r = 32'hFFFF_FFFF;
        e.h = x;
        e.d = 1;
      end else begin
        e.r = x / y;
        e.h = x % y;
        e.lat = 33;
      end
      default: e.r = 0;
    endcase
    e.z = e.r == 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      seen = 0;
      inflight = 0;
      idle_chk = 0;
    end else begin
      if (idle_chk) begin
        chk("idle_after_ack", 128'({in_ready, out_valid}), 128'(2'b10));
        idle_chk = 0;
      end
      if (out_valid) begin
        chk("ready_in_done", 128'(in_ready), 128'(0));
        if (!seen) begin
          seen = 1;
          lat = cyc - acc_cyc + 1;
          snap = {result, result_hi, zero, div_by_zero};
        end else chk("hold_stable", 128'({result, result_hi, zero, div_by_zero}), 128'(snap));
        if (out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_out", 128'(1), 128'(0));
          else begin
            e = exp_q.pop_front();
            chk("result", 128'(result), 128'(e.r));
            chk("result_hi", 128'(result_hi), 128'(e.h));
            chk("zero", 128'(zero), 128'(e.z));
            chk("div_by_zero", 128'(div_by_zero), 128'(e.d));
            chk("latency", 128'(lat), 128'(e.lat));
          end
          seen = 0;
          inflight = 0;
          idle_chk = 1;
        end
      end else if (inflight) chk("ready_in_busy", 128'(in_ready), 128'(0));
      if (in_valid && in_ready) begin
        acc_cyc = cyc + 1;
        inflight = 1;
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk);
    #1;
    in_valid = 1;
    op = o;
    a = x;
    b = y;
    for (int i = 0; i < 500 && !(resetn && in_ready); i++) @(negedge clk);
    if (!in_ready) begin
      chk("accept_timeout", 128'(in_ready), 128'(1));
      in_valid = 0;
      return;
    end
    exp_q.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    in_valid = 0;
    a = $urandom;
    b = $urandom;
    op = 4'($urandom);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready && exp_q.size() == 0) break;
    end
    if (i == 500) chk("idle_timeout", 128'(in_ready), 128'(1));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] x, y;
    resetn = 0;
    in_valid = 0;
    out_ready = 1;
    op = 0;
    a = 0;
    b = 0;
    #24;
    chk("reset_outs", 128'({out_valid, result, result_hi, zero, div_by_zero}), 128'(0));
    chk("reset_ready", 128'(in_ready), 128'(1));
    fork
      issue(4'b0110, 32'd5, 32'd7);
      begin #4 resetn = 1; end
    join
    issue(4'b0111, 32'd5, 32'd7);
    issue(4'b0011, 32'hFFFF_FFFF, 32'd1);
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
    issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(4'b1001, 32'd100, 32'd7);
    issue(4'b1001, 32'd9, 32'd0);
    issue(4'b1100, 32'h1234, 32'h5678);
    issue(4'b0100, 32'hF0F0_FFFF, 32'h0FF0_00FF);
    issue(4'b0101, 32'h0000_0000, 32'hFFFF_0000);
    issue(4'b1000, 32'd0, 32'hDEAD_BEEF);
    issue(4'b1001, 32'd3, 32'd10);
    wait_idle();
    bp_mode = 1;
    issue(4'b0010, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1;
      op = 4'($urandom);
      a = $urandom;
      b = $urandom;
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    bp_mode = 2;
    wait_idle();
    issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(posedge clk);
    #2 resetn = 0;
    #1;
    chk("midbusy_rst_outs", 128'({out_valid, result, result_hi, zero, div_by_zero}), 128'(0));
    chk("midbusy_rst_ready", 128'(in_ready), 128'(1));
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #2 resetn = 1;
    #1 chk("post_rst_valid", 128'(out_valid), 128'(0));
    issue(4'b0010, 32'd3, 32'd4);
    bp_mode = 0;
    for (int k = 0; k < 200; k++) begin
      x = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 300)) : $urandom;
      y = $urandom_range(0, 5) == 0 ? 32'd0 : ($urandom_range(0, 2) == 0 ? 32'($urandom_range(1, 20)) : $urandom);
      issue(4'($urandom_range(0, 15)), x, y);
    end
    bp_mode = 2;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
